// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Per-register latency scoreboard for the ID stage. Each architectural
// register (except x0) carries a small down-counter that reads nonzero while
// an in-flight producer has not yet made its result forwardable. The ID
// instruction is held on read-after-write and write-after-write hazards, and
// on a busy multi-cycle unit in EX. Taken branches and kills flush the front
// end and take priority over any stall.

module hazard_scoreboard #(
    parameter  int NUM_REGS = 32,
    parameter  int MAX_LAT  = 8,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int CW       = $clog2(MAX_LAT + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_id_valid,
    input  logic [AW-1:0]       i_id_rs1_addr,
    input  logic [AW-1:0]       i_id_rs2_addr,
    input  logic                i_id_rs1_use,
    input  logic                i_id_rs2_use,
    input  logic [AW-1:0]       i_id_rd_addr,
    input  logic                i_id_regfile_we,
    input  logic [CW-1:0]       i_id_lat,
    input  logic                i_ex_busy,
    input  logic                i_ex_take_branch,
    input  logic                i_kill,
    output logic                o_stall_if,
    output logic                o_stall_ifid,
    output logic                o_flush_ifid,
    output logic                o_flush_idex,
    output logic                o_bubble_idex,
    output logic                o_issue,
    output logic [NUM_REGS-1:0] o_pending
);

    // Largest legal latency, sized to the counter width so comparisons stay
    // width-matched.
    localparam logic [CW-1:0] LAT_LIMIT = CW'(MAX_LAT);

    // Remaining cycles until each register's pending result is forwardable.
    // Entry 0 is held at zero so x0 can be indexed like any other register.
    logic [CW-1:0] r_cnt [NUM_REGS];

    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_raw;
    logic w_waw;
    logic w_haz;
    logic w_stall;
    logic w_redirect;
    logic w_issue;
    logic w_write;
    logic [NUM_REGS-1:0] w_pending;

    // Hazard detection against the current scoreboard contents. A younger
    // write must not be overtaken by an older, slower one, hence the WAW
    // check only fires when the outstanding count exceeds the new latency.
    always_comb begin
        w_rs1_busy = i_id_rs1_use && (r_cnt[i_id_rs1_addr] != '0);
        w_rs2_busy = i_id_rs2_use && (r_cnt[i_id_rs2_addr] != '0);
        w_raw      = w_rs1_busy || w_rs2_busy;
        w_waw      = i_id_regfile_we && (i_id_rd_addr != '0) &&
                     (r_cnt[i_id_rd_addr] > i_id_lat);
        w_haz      = i_id_valid && (w_raw || w_waw);
        w_stall    = w_haz || i_ex_busy;
        w_redirect = i_ex_take_branch || i_kill;
        w_issue    = i_id_valid && !w_stall && !w_redirect;
        w_write    = w_issue && i_id_regfile_we && (i_id_rd_addr != '0);
    end

    // Pipeline control. A redirect always wins over a stall; while EX is busy
    // the ID/EX register holds its contents rather than taking a bubble.
    always_comb begin
        o_stall_if    = w_stall && !w_redirect;
        o_stall_ifid  = w_stall && !w_redirect;
        o_bubble_idex = w_stall && !w_redirect && !i_ex_busy;
        o_flush_ifid  = w_redirect;
        o_flush_idex  = w_redirect;
        o_issue       = w_issue;
    end

    // Debug view of which registers still have an outstanding producer.
    always_comb begin
        w_pending = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_pending[r] = (r_cnt[r] != '0);
        end
    end

    assign o_pending = w_pending;

    // Scoreboard update: kill clears everything, otherwise counters drain by
    // one per cycle and an issuing writer loads its declared latency, which
    // takes precedence over the drain on the same register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else if (i_kill) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_write && (i_id_rd_addr == AW'(r))) begin
                    r_cnt[r] <= i_id_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - CW'(1);
                end
            end
        end
    end

    // A producer may never declare more latency than the counters are sized for.
    a_lat_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_id_valid && i_id_regfile_we) |-> (i_id_lat <= LAT_LIMIT));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard. Inputs are driven just after the
// falling clock edge and outputs are sampled 1ns later, well before the next
// rising edge.

module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int MAX_LAT  = 8;
    localparam int AW       = $clog2(NUM_REGS);
    localparam int CW       = $clog2(MAX_LAT + 1);

    // Control vector order: stall_if, stall_ifid, bubble_idex, flush_ifid, flush_idex, issue
    localparam logic [5:0] CTL_IDLE     = 6'b000000;
    localparam logic [5:0] CTL_ISSUE    = 6'b000001;
    localparam logic [5:0] CTL_HAZARD   = 6'b111000;
    localparam logic [5:0] CTL_BUSY     = 6'b110000;
    localparam logic [5:0] CTL_REDIRECT = 6'b000110;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                id_valid = 1'b0;
    logic [AW-1:0]       rs1 = '0;
    logic [AW-1:0]       rs2 = '0;
    logic                rs1_use = 1'b0;
    logic                rs2_use = 1'b0;
    logic [AW-1:0]       rd = '0;
    logic                we = 1'b0;
    logic [CW-1:0]       lat = '0;
    logic                ex_busy = 1'b0;
    logic                take_branch = 1'b0;
    logic                kill = 1'b0;
    logic                stall_if;
    logic                stall_ifid;
    logic                flush_ifid;
    logic                flush_idex;
    logic                bubble_idex;
    logic                issue;
    logic [NUM_REGS-1:0] pending;
    logic [5:0]          ctl;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .MAX_LAT(MAX_LAT)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_id_valid       (id_valid),
        .i_id_rs1_addr    (rs1),
        .i_id_rs2_addr    (rs2),
        .i_id_rs1_use     (rs1_use),
        .i_id_rs2_use     (rs2_use),
        .i_id_rd_addr     (rd),
        .i_id_regfile_we  (we),
        .i_id_lat         (lat),
        .i_ex_busy        (ex_busy),
        .i_ex_take_branch (take_branch),
        .i_kill           (kill),
        .o_stall_if       (stall_if),
        .o_stall_ifid     (stall_ifid),
        .o_flush_ifid     (flush_ifid),
        .o_flush_idex     (flush_idex),
        .o_bubble_idex    (bubble_idex),
        .o_issue          (issue),
        .o_pending        (pending)
    );

    assign ctl = {stall_if, stall_ifid, bubble_idex, flush_ifid, flush_idex, issue};

    always #5 clk = ~clk;

    // Drive the ID instruction fields.
    task automatic set_id(input int v, input int a1, input int u1, input int a2,
                          input int u2, input int d, input int w, input int l);
        id_valid = (v != 0);
        rs1      = AW'(a1);
        rs1_use  = (u1 != 0);
        rs2      = AW'(a2);
        rs2_use  = (u2 != 0);
        rd       = AW'(d);
        we       = (w != 0);
        lat      = CW'(l);
    endtask

    // Empty ID slot and no EX-side events.
    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_busy     = 1'b0;
        take_branch = 1'b0;
        kill        = 1'b0;
    endtask

    // Let every outstanding counter run out.
    task automatic drain();
        @(negedge clk);
        idle();
        repeat (9) @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        @(negedge clk); #1;
        checks++;
        if (pending !== '0) begin
            errors++; $display("[TB] FAIL reset_pending: got %h expected %h", pending, 32'h0);
        end
        checks++;
        if (ctl !== CTL_IDLE) begin
            errors++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, CTL_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
        set_id(1, 1, 1, 2, 1, 3, 1, 0);
        #1;
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL reset_first_issue: got %b expected %b", ctl, CTL_ISSUE);
        end
        drain();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        #1;
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL lu_load_issue: got %b expected %b", ctl, CTL_ISSUE);
        end
        @(negedge clk);
        set_id(1, 5, 1, 0, 0, 6, 1, 0);
        #1;
        checks++;
        if (ctl !== CTL_HAZARD) begin
            errors++; $display("[TB] FAIL lu_bubble: got %b expected %b", ctl, CTL_HAZARD);
        end
        checks++;
        if (pending !== 32'h0000_0020) begin
            errors++; $display("[TB] FAIL lu_pending_set: got %h expected %h", pending, 32'h0000_0020);
        end
        @(negedge clk); #1;
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL lu_use_issue: got %b expected %b", ctl, CTL_ISSUE);
        end
        checks++;
        if (pending !== '0) begin
            errors++; $display("[TB] FAIL lu_pending_clear: got %h expected %h", pending, 32'h0);
        end
        drain();
    endtask

    task automatic test_div_latency();
        int n;
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 7, 1, 6);
        #1;
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL div_issue: got %b expected %b", ctl, CTL_ISSUE);
        end
        @(negedge clk);
        set_id(1, 7, 1, 0, 0, 10, 1, 0);
        #1;
        n = 0;
        while (!issue && n < 20) begin
            checks++;
            if (ctl !== CTL_HAZARD) begin
                errors++; $display("[TB] FAIL div_stall_ctl: got %b expected %b", ctl, CTL_HAZARD);
            end
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("[TB] FAIL div_stall_cycles: got %0d expected %0d", n, 6);
        end
        drain();
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 7, 1, 6);
        @(negedge clk);
        set_id(1, 8, 1, 0, 1, 11, 1, 0);
        #1;
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL div_independent: got %b expected %b", ctl, CTL_ISSUE);
        end
        drain();
    endtask

    task automatic test_waw();
        int n;
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 3, 1, 6);
        @(negedge clk);
        set_id(1, 0, 1, 0, 0, 3, 1, 0);
        #1;
        n = 0;
        while (!issue && n < 20) begin
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("[TB] FAIL waw_stall_cycles: got %0d expected %0d", n, 6);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (pending[3] !== 1'b0) begin
            errors++; $display("[TB] FAIL waw_cnt_after: got %b expected %b", pending[3], 1'b0);
        end
        // Equal latency cannot reorder, so no stall.
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 3, 1, 6);
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 3, 1, 6);
        #1;
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL waw_equal_lat: got %b expected %b", ctl, CTL_ISSUE);
        end
        drain();
    endtask

    task automatic test_branch_hazard();
        int n;
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 5, 1, 3);
        @(negedge clk);
        set_id(1, 5, 1, 0, 0, 12, 1, 5);
        take_branch = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_REDIRECT) begin
            errors++; $display("[TB] FAIL br_ctl: got %b expected %b", ctl, CTL_REDIRECT);
        end
        @(negedge clk);
        take_branch = 1'b0;
        set_id(1, 5, 1, 0, 0, 13, 1, 0);
        #1;
        checks++;
        if (pending !== 32'h0000_0020) begin
            errors++; $display("[TB] FAIL br_no_wrong_path_write: got %h expected %h", pending, 32'h0000_0020);
        end
        n = 0;
        while (!issue && n < 20) begin
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n !== 2) begin
            errors++; $display("[TB] FAIL br_countdown: got %0d expected %0d", n, 2);
        end
        drain();
    endtask

    task automatic test_kill_reset();
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 4, 1, 6);
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 9, 1, 3);
        @(negedge clk);
        set_id(1, 4, 1, 0, 0, 11, 1, 4);
        kill = 1'b1;
        #1;
        checks++;
        if (pending !== 32'h0000_0210) begin
            errors++; $display("[TB] FAIL kill_before: got %h expected %h", pending, 32'h0000_0210);
        end
        checks++;
        if (ctl !== CTL_REDIRECT) begin
            errors++; $display("[TB] FAIL kill_ctl: got %b expected %b", ctl, CTL_REDIRECT);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (pending !== '0) begin
            errors++; $display("[TB] FAIL kill_after: got %h expected %h", pending, 32'h0);
        end
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 4, 1, 6);
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 9, 1, 3);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (pending !== 32'h0000_0210) begin
            errors++; $display("[TB] FAIL rst_before: got %h expected %h", pending, 32'h0000_0210);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pending !== '0) begin
            errors++; $display("[TB] FAIL rst_async: got %h expected %h", pending, 32'h0);
        end
        rst = 1'b0;
        drain();
    endtask

    task automatic test_x0_busy();
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        set_id(1, 0, 1, 0, 1, 0, 1, 0);
        #1;
        checks++;
        if (pending !== '0) begin
            errors++; $display("[TB] FAIL x0_pending: got %h expected %h", pending, 32'h0);
        end
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL x0_reader: got %b expected %b", ctl, CTL_ISSUE);
        end
        @(negedge clk);
        set_id(1, 0, 0, 0, 0, 2, 1, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_id(1, 0, 0, 0, 0, 14, 1, 0);
            ex_busy = 1'b1;
            #1;
            checks++;
            if (ctl !== CTL_BUSY) begin
                errors++; $display("[TB] FAIL busy_ctl[%0d]: got %b expected %b", k, ctl, CTL_BUSY);
            end
        end
        @(negedge clk);
        ex_busy = 1'b0;
        set_id(1, 2, 1, 0, 0, 15, 1, 0);
        #1;
        checks++;
        if (ctl !== CTL_ISSUE) begin
            errors++; $display("[TB] FAIL busy_drained: got %b expected %b", ctl, CTL_ISSUE);
        end
        drain();
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_load_use();
        test_div_latency();
        test_waw();
        test_branch_hazard();
        test_kill_reset();
        test_x0_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
